// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmit path among NUM_REQ byte producers using round-robin
// arbitration. uart_tx has no busy output, so this block paces its own start
// strobes with a frame timer. Under continuous requests, consecutive
// tx_data_valid strobes are exactly FRAME_CYCLES clocks apart.
//
// Ports:
//   clk            system clock
//   rst            asynchronous, active-high reset
//   req_valid      per-requester byte-pending flag (held until req_ready)
//   req_data       requester i's byte at bits [8i+7:8i]
//   req_ready      one-cycle, one-hot accept pulse
//   tx_data_valid  one-cycle start strobe to uart_tx
//   tx_data_in     byte to uart_tx, held until the next grant
//   grant_id       index of the last granted requester
//   busy           high while a frame is in flight (state != IDLE)
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int BPS_PARA   = 1250,
  parameter int FRAME_BITS = 10,
  parameter int GAP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_data_valid,
  output logic [7:0]           tx_data_in,
  output logic [2:0]           grant_id,
  output logic                 busy
);

  localparam int FRAME_CYCLES = BPS_PARA * (FRAME_BITS + GAP_BITS);
  localparam int CNT_W        = $clog2(FRAME_CYCLES);
  // The grant edge plus (FRAME_CYCLES-2)+1 WAIT edges plus one IDLE edge make
  // the strobe-to-strobe spacing exactly FRAME_CYCLES clocks.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CYCLES - 2);

  generate
    if (FRAME_CYCLES < 3) begin : g_bad_frame
      $error("uart_tx_arbiter: FRAME_CYCLES must be >= 3");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_ptr;
  logic [NUM_REQ-1:0] r_ready;
  logic               r_valid;
  logic [7:0]         r_data;
  logic [2:0]         r_gid;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [2:0]         w_ptr_nxt;
  logic [NUM_REQ-1:0] w_ready_nxt;
  logic               w_valid_nxt;
  logic [7:0]         w_data_nxt;
  logic [2:0]         w_gid_nxt;

  logic               w_found;
  logic [2:0]         w_win;
  logic [7:0]         w_win_data;

  // Round-robin search: offset k from the pointer, first set request wins.
  // The inner loop over j keeps every bit/part select at a constant index.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    w_found    = 1'b0;
    w_win      = '0;
    w_win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!w_found && req_valid[j] && (j == (int'(r_ptr) + k) % NUM_REQ)) begin
          w_found    = 1'b1;
          w_win      = 3'(j);
          w_win_data = req_data[8*j +: 8];
        end
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_ready_nxt = '0;
    w_valid_nxt = 1'b0;
    w_data_nxt  = r_data;
    w_gid_nxt   = r_gid;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CNT_LOAD;
          w_ptr_nxt   = (w_win == 3'(NUM_REQ - 1)) ? 3'd0 : w_win + 3'd1;
          w_valid_nxt = 1'b1;
          w_data_nxt  = w_win_data;
          w_gid_nxt   = w_win;
          for (int j = 0; j < NUM_REQ; j++) begin
            w_ready_nxt[j] = (w_win == 3'(j));
          end
        end
      end
      S_WAIT: begin
        // Requests are deliberately not sampled here.
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_ready <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_gid   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the values from before the edge, independent of statement order.
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_ready <= w_ready_nxt;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
      r_gid   <= w_gid_nxt;
    end
  end

  assign req_ready     = r_ready;
  assign tx_data_valid = r_valid;
  assign tx_data_in    = r_data;
  assign grant_id      = r_gid;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter with NUM_REQ=4, BPS_PARA=4
// (FRAME_CYCLES=44). A timing-level model derives the expected outputs from
// the number of edges since the last grant and a round-robin pointer. Every
// output is compared against the model on each falling edge. Hand-computed
// literals pin the grant order, byte values, spacing and busy duration.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int BPS = 4;
  localparam int FB = 10;
  localparam int GB = 1;
  localparam int F  = BPS * (FB + GB);   // 44

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             tx_data_valid;
  logic [7:0]       tx_data_in;
  logic [2:0]       grant_id;
  logic             busy;

  uart_tx_arbiter #(
    .NUM_REQ   (N),
    .BPS_PARA  (BPS),
    .FRAME_BITS(FB),
    .GAP_BITS  (GB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .tx_data_valid(tx_data_valid),
    .tx_data_in   (tx_data_in),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_since counts edges since the last grant, saturating at F-1. A new
  // grant is allowed once F clocks have elapsed since the previous one.
  int           m_since;
  int           m_ptr;
  logic [N-1:0] e_ready;
  logic         e_valid;
  logic [7:0]   e_data;
  logic [2:0]   e_gid;
  logic         e_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_since = F - 1;
      m_ptr   = 0;
      e_ready = '0;
      e_valid = 1'b0;
      e_data  = 8'h00;
      e_gid   = 3'd0;
      e_busy  = 1'b0;
    end else begin
      int w;
      w       = -1;
      e_ready = '0;
      e_valid = 1'b0;
      if (m_since >= F - 1) begin
        for (int k = 0; k < N; k++) begin
          if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        end
      end
      if (w >= 0) begin
        e_ready    = '0;
        e_ready[w] = 1'b1;
        e_valid    = 1'b1;
        e_data     = req_data[8*w +: 8];
        e_gid      = 3'(w);
        m_ptr      = (w + 1) % N;
        m_since    = 0;
      end else if (m_since < F - 1) begin
        m_since++;
      end
      e_busy = (m_since <= F - 2);
    end
  end

  // ---------------- compare process and grant log ----------------
  int           cyc = 0;
  int           busy_cnt = 0;
  logic         odd_seen = 1'b0;
  int           q_id[$];
  int           q_t[$];
  logic [7:0]   q_data[$];
  logic [N-1:0] q_rdy[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      check("ready", 32'(req_ready), 32'(e_ready));
      check("tx_valid", 32'(tx_data_valid), 32'(e_valid));
      check("tx_data", 32'(tx_data_in), 32'(e_data));
      check("grant_id", 32'(grant_id), 32'(e_gid));
      check("busy", 32'(busy), 32'(e_busy));
      if (busy) busy_cnt++;
      if (req_ready[1] || req_ready[3]) odd_seen = 1'b1;
      if (tx_data_valid) begin
        q_id.push_back(int'(grant_id));
        q_t.push_back(cyc);
        q_data.push_back(tx_data_in);
        q_rdy.push_back(req_ready);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Inputs change 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    q_id.delete();
    q_t.delete();
    q_data.delete();
    q_rdy.delete();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    clear_log();
    step(2);
    rst = 1'b0;
  endtask

  task automatic wait_grants(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (q_id.size() < n && k < budget) begin
      step(1);
      k++;
    end
    if (q_id.size() < n) check(name, 32'(q_id.size()), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ids[5];
    int t_req;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    step(1);

    // ---- reset state ----
    do_reset();
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_valid", 32'(tx_data_valid), 32'h0);
    check("rst_data", 32'(tx_data_in), 32'h00);
    check("rst_gid", 32'(grant_id), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // ---- single request: requester 2, byte A5 ----
    busy_cnt        = 0;
    req_data[23:16] = 8'hA5;
    req_valid       = 4'b0100;
    t_req           = cyc;
    wait_grants(1, 10, "t1_timeout");
    req_valid = '0;
    check("t1_latency", 32'(q_t[0] - t_req), 32'd1);
    check("t1_ready", 32'(q_rdy[0]), 32'h4);
    check("t1_data", 32'(q_data[0]), 32'hA5);
    check("t1_gid", 32'(q_id[0]), 32'd2);
    step(60);
    check("t1_busy_cycles", 32'(busy_cnt), 32'd43);
    check("t1_busy_low", 32'(busy), 32'h0);
    check("t1_one_grant", 32'(q_id.size()), 32'd1);

    // ---- all four continuously requesting ----
    do_reset();
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b1111;
    wait_grants(5, 5 * F + 10, "t2_timeout");
    req_valid = '0;
    exp_ids = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_id%0d", i), 32'(q_id[i]), 32'(exp_ids[i]));
      check($sformatf("t2_data%0d", i), 32'(q_data[i]), 32'(8'h10 + exp_ids[i]));
      if (i > 0) check($sformatf("t2_gap%0d", i), 32'(q_t[i] - q_t[i-1]), 32'd44);
    end

    // ---- requesters 0 and 2 continuously active ----
    do_reset();
    odd_seen  = 1'b0;
    req_valid = 4'b0101;
    wait_grants(4, 4 * F + 10, "t3_timeout");
    req_valid = '0;
    exp_ids = '{0, 2, 0, 2, 0};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_id%0d", i), 32'(q_id[i]), 32'(exp_ids[i]));
    end
    check("t3_odd_never_ready", 32'(odd_seen), 32'h0);

    // ---- request 1 arriving mid-frame ----
    do_reset();
    req_valid = 4'b0001;
    wait_grants(1, 10, "t4_timeout0");
    req_valid = '0;
    step(9);
    req_valid = 4'b0010;
    wait_grants(2, 2 * F, "t4_timeout1");
    req_valid = '0;
    check("t4_id", 32'(q_id[1]), 32'd1);
    check("t4_gap", 32'(q_t[1] - q_t[0]), 32'd44);

    // ---- reset asserted mid-frame ----
    do_reset();
    req_data[23:16] = 8'h5A;
    req_valid       = 4'b0100;
    wait_grants(1, 10, "t5_timeout0");
    req_valid = '0;
    step(19);
    check("t5_busy_before", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check("t5_ready", 32'(req_ready), 32'h0);
    check("t5_valid", 32'(tx_data_valid), 32'h0);
    check("t5_data", 32'(tx_data_in), 32'h00);
    check("t5_gid", 32'(grant_id), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    step(2);
    clear_log();
    rst       = 1'b0;
    req_valid = 4'b1010;
    wait_grants(1, 10, "t5_timeout1");
    req_valid = '0;
    check("t5_gid_after", 32'(q_id[0]), 32'd1);

    // ---- one-cycle request during WAIT only ----
    do_reset();
    req_valid = 4'b0001;
    wait_grants(1, 10, "t6_timeout");
    req_valid = '0;
    step(5);
    req_valid = 4'b1000;
    step(1);
    req_valid = '0;
    step(F + 20);
    check("t6_no_grant", 32'(q_id.size()), 32'd1);
    check("t6_valid", 32'(tx_data_valid), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
